// File: rtl/adc_spi_in.sv
// SPI mode-0 slave receiver: oversamples CS/SCK/MOSI in the fabric clock domain
// and delivers each completed two-word frame as parallel registers plus a one-cycle strobe.
module adc_spi_in #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_SPI_CS,
    input  logic                  i_SPI_clock,
    input  logic                  i_SPI_data,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic                  o_data_received
);

    localparam int FRAME_BITS = 2 * DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;

    logic                   cs_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   sck_rise;

    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q,    shift_d;
    logic [DATA_WIDTH-1:0]  data0_q,    data0_d;
    logic [DATA_WIDTH-1:0]  data1_q,    data1_d;
    logic                   strobe_q,   strobe_d;

    // CS synchronizer resets to the idle (deasserted) level so a reset never looks like a frame start
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   i_SPI_CS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  i_SPI_clock};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_data};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        strobe_d  = 1'b0;
        if (cs_s) begin
            bit_cnt_d = '0;
        end else if (sck_rise && (bit_cnt_q < CNT_W'(FRAME_BITS))) begin
            shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Publish from the next-state shift value so the final bit lands in this same cycle
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                data0_d  = shift_d[FRAME_BITS-1:DATA_WIDTH];
                data1_d  = shift_d[DATA_WIDTH-1:0];
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data0_q   <= '0;
            data1_q   <= '0;
            strobe_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            strobe_q  <= strobe_d;
        end
    end

    assign o_data0         = data0_q;
    assign o_data1         = data1_q;
    assign o_data_received = strobe_q;

endmodule

// File: tb/tb_adc_spi_in.sv
// Bench for adc_spi_in: directed and random SPI frames, checked every cycle against a
// frame-level model (expected words, strobe deadline after the 32nd SCK edge).
`timescale 1ns/1ps
module tb_adc_spi_in;

    localparam int DW   = 16;
    localparam int SYNC = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          cs   = 1'b1;
    logic          sck  = 1'b0;
    logic          mosi = 1'b0;
    logic [DW-1:0] o_data0;
    logic [DW-1:0] o_data1;
    logic          o_data_received;

    adc_spi_in #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_SPI_CS        (cs),
        .i_SPI_clock     (sck),
        .i_SPI_data      (mosi),
        .o_data0         (o_data0),
        .o_data1         (o_data1),
        .o_data_received (o_data_received)
    );

    always #4 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    longint  cyc    = 0;

    // frame-level model
    int          edges_m  = 0;
    logic [31:0] frame_m  = '0;
    bit          pend     = 1'b0;
    longint      pend_cyc = 0;
    logic [15:0] exp0 = '0, exp1 = '0, new0 = '0, new1 = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            exp0 = '0;
            exp1 = '0;
            pend = 1'b0;
        end else begin
            checks++;
            if (o_data_received === 1'b1) begin
                if (!pend) begin
                    errors++;
                    $display("FAIL strobe_unexpected cyc=%0d got=1 want=0", cyc);
                end else begin
                    exp0 = new0;
                    exp1 = new1;
                    pend = 1'b0;
                end
            end else if (o_data_received !== 1'b0) begin
                errors++;
                $display("FAIL strobe_x cyc=%0d got=%b want=0/1", cyc, o_data_received);
            end else if (pend && (cyc - pend_cyc > SYNC + 2)) begin
                errors++;
                $display("FAIL strobe_late cyc=%0d got=0 want=1 (edge32 at cyc %0d)", cyc, pend_cyc);
                exp0 = new0;
                exp1 = new1;
                pend = 1'b0;
            end
            checks++;
            if ({o_data0, o_data1} !== {exp0, exp1}) begin
                errors++;
                $display("FAIL data_cycle cyc=%0d got=%h_%h want=%h_%h", cyc, o_data0, o_data1, exp0, exp1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int half);
        mosi = b;
        tick(half);
        sck = 1'b1;
        if (!cs && edges_m < 32) begin
            frame_m = {frame_m[30:0], b};
            edges_m++;
            if (edges_m == 32) begin
                new0     = frame_m[31:16];
                new1     = frame_m[15:0];
                pend     = 1'b1;
                pend_cyc = cyc;
            end
        end
        tick(half / 2);
        mosi = 1'($urandom);
        tick(half - half / 2);
        sck = 1'b0;
    endtask

    task automatic start_frame();
        cs      = 1'b0;
        edges_m = 0;
        frame_m = '0;
        tick(4);
    endtask

    task automatic end_frame();
        tick(4);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic frame(input logic [63:0] bits, input int n, input int half);
        start_frame();
        for (int i = 0; i < n; i++) send_bit(bits[63-i], half);
        end_frame();
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    initial begin
        logic [63:0] bits;
        int          n, half;

        tick(3);
        rst = 1'b0;
        tick(2);
        check16("reset_d0", o_data0, 16'h0000);
        check16("reset_d1", o_data1, 16'h0000);
        check16("reset_strobe", {15'd0, o_data_received}, 16'h0000);

        // frame 1, ~380 ns half periods
        bits = {16'h00C8, 16'hFEAC, 32'h0};
        frame(bits, 32, 47);
        check16("f1_d0", o_data0, 16'h00C8);
        check16("f1_d1", o_data1, 16'hFEAC);
        $display("frame1 d0=%h d1=%h", o_data0, o_data1);

        tick(1250);
        bits = {16'h004B, 16'h5533, 32'h0};
        frame(bits, 32, 47);
        tick(1250);
        check16("f2_d0_hold", o_data0, 16'h004B);
        check16("f2_d1_hold", o_data1, 16'h5533);
        $display("frame2 d0=%h d1=%h", o_data0, o_data1);

        // aborted frame, then a full one
        bits = {16'hFFFF, 16'hFFFF, 32'h0};
        frame(bits, 20, 10);
        check16("abort_d0", o_data0, 16'h004B);
        check16("abort_d1", o_data1, 16'h5533);
        bits = {16'h1234, 16'hABCD, 32'h0};
        frame(bits, 32, 10);
        check16("after_abort_d0", o_data0, 16'h1234);
        check16("after_abort_d1", o_data1, 16'hABCD);
        $display("abort+frame d0=%h d1=%h", o_data0, o_data1);

        // over-length frame
        bits = {16'h8001, 16'h7FFE, 8'hA5, 24'h0};
        frame(bits, 40, 8);
        check16("over_d0", o_data0, 16'h8001);
        check16("over_d1", o_data1, 16'h7FFE);
        $display("overlength d0=%h d1=%h", o_data0, o_data1);

        // reset mid-frame
        start_frame();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 6);
        tick(2);
        rst     = 1'b1;
        edges_m = 0;
        frame_m = '0;
        tick(2);
        rst = 1'b0;
        tick(4);
        for (int i = 0; i < 22; i++) send_bit(1'($urandom), 6);
        end_frame();
        check16("rstmid_d0", o_data0, 16'h0000);
        check16("rstmid_d1", o_data1, 16'h0000);
        bits = {16'hC0DE, 16'h0F0F, 32'h0};
        frame(bits, 32, 6);
        check16("after_rst_d0", o_data0, 16'hC0DE);
        check16("after_rst_d1", o_data1, 16'h0F0F);
        $display("reset-mid then frame d0=%h d1=%h", o_data0, o_data1);

        // random frames: mostly full, some aborted, some over-length
        for (int f = 0; f < 30; f++) begin
            bits = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, 31);
                1:       n = $urandom_range(33, 40);
                default: n = 32;
            endcase
            half = $urandom_range(3, 9);
            frame(bits, n, half);
            $display("rand frame %0d bits=%0d half=%0d d0=%h d1=%h", f, n, half, o_data0, o_data1);
        end

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
